// File: rtl/uart_tx_fifo_sync_fifo.sv
// Parameterised synchronous FIFO: registered pointers, exact occupancy count,
// and a sticky overflow flag. Read data is the entry at the read pointer.
module sync_fifo #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_BITS-1:0]  wr_data,
  input  logic                  rd_en,
  output logic [DATA_BITS-1:0]  rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_BITS-1:0]  mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;

  // Acceptance uses the registered full flag, so a pop in the same cycle
  // never frees room for a write that arrives while full.
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer ahead of uart_tx: stores producer bursts and drains them one
// byte per transmission through the uart_tx start/ready handshake.
module uart_tx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_BITS-1:0]  wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  input  logic                  tx_ready,
  output logic                  tx_start,
  output logic [DATA_BITS-1:0]  tx_data
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 start_nxt;
  logic [DATA_BITS-1:0] data_nxt;
  logic                 pop;
  logic [DATA_BITS-1:0] rd_data;

  sync_fifo #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (rd_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  // WAIT_BUSY holds off the next pop until uart_tx has dropped ready,
  // so each start pulse maps to exactly one transmitted byte.
  always_comb begin
    state_nxt = state;
    start_nxt = 1'b0;
    data_nxt  = tx_data;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && tx_ready) begin
          pop       = 1'b1;
          start_nxt = 1'b1;
          data_nxt  = rd_data;
          state_nxt = START;
        end
      end
      START: begin
        state_nxt = tx_ready ? WAIT_BUSY : IDLE;
      end
      WAIT_BUSY: begin
        if (!tx_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      state    <= state_nxt;
      tx_start <= start_nxt;
      tx_data  <= data_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based reference model checked every cycle,
// a serial uart_tx stand-in with decoder, and directed literal checks.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int CPB   = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tb_ready = 1'b1;
  logic       sel = 1'b0;
  logic       tx_ready;
  logic       full, empty, overflow, tx_start;
  logic [4:0] count;
  logic [7:0] tx_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_BITS(8), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_ready (tx_ready),
    .tx_start (tx_start),
    .tx_data  (tx_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Serial transmitter stand-in: ready while idle, 10-bit frame, CPB clocks/bit.
  logic       u_busy = 1'b0;
  logic       u_line = 1'b1;
  logic [9:0] u_frame = '0;
  int         u_cnt = 0;
  int         u_bit = 0;

  assign tx_ready = sel ? !u_busy : tb_ready;

  always @(posedge clk) begin
    if (reset) begin
      u_busy <= 1'b0;
      u_line <= 1'b1;
      u_cnt  <= 0;
      u_bit  <= 0;
    end else if (!u_busy) begin
      if (tx_start && sel) begin
        u_busy  <= 1'b1;
        u_frame <= {1'b1, tx_data, 1'b0};
        u_line  <= 1'b0;
        u_cnt   <= 0;
        u_bit   <= 0;
      end
    end else if (u_cnt == CPB-1) begin
      u_cnt <= 0;
      if (u_bit == 9) begin
        u_busy <= 1'b0;
        u_line <= 1'b1;
      end else begin
        u_bit  <= u_bit + 1;
        u_line <= u_frame[u_bit+1];
      end
    end else begin
      u_cnt <= u_cnt + 1;
    end
  end

  // Line decoder sampling mid-bit.
  logic [7:0] rx_q[$];
  logic [7:0] rx_sh = '0;
  bit         rx_act = 0;
  int         rx_cnt = 0;
  int         rx_k = 0;

  always @(posedge clk) begin
    if (reset) begin
      rx_act = 0;
    end else if (!rx_act) begin
      if (!u_line) begin
        rx_act = 1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= 6 && (rx_cnt % 4) == 2) begin
        rx_k = (rx_cnt - 2) / 4;
        if (rx_k <= 8) rx_sh[rx_k-1] = u_line;
        else begin
          chk("rx_stop_bit", {31'd0, u_line}, 32'd1);
          rx_q.push_back(rx_sh);
          rx_act = 0;
        end
      end
    end
  end

  // Reference model: byte queue plus drain phase (0 idle, 1 pulsed, 2 awaiting busy).
  logic [7:0] q[$];
  int         m_ph = 0;
  bit         m_start = 0;
  logic [7:0] m_data = '0;
  bit         m_ovf = 0;
  bit         started = 0;
  bit         m_was_full, m_was_empty;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_ph    = 0;
      m_start = 0;
      m_data  = '0;
      m_ovf   = 0;
      started = 1;
    end else if (started) begin
      m_was_full  = (q.size() == DEPTH);
      m_was_empty = (q.size() == 0);
      case (m_ph)
        0: if (!m_was_empty && tx_ready) begin
             m_start = 1;
             m_data  = q.pop_front();
             m_ph    = 1;
           end
        1: begin
             m_start = 0;
             m_ph    = tx_ready ? 2 : 0;
           end
        default: if (!tx_ready) m_ph = 0;
      endcase
      if (wr_en) begin
        if (m_was_full) m_ovf = 1;
        else q.push_back(wr_data);
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("count", {27'd0, count}, q.size());
      chk("empty", {31'd0, empty}, {31'd0, q.size() == 0});
      chk("full", {31'd0, full}, {31'd0, q.size() == DEPTH});
      chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      chk("tx_start", {31'd0, tx_start}, {31'd0, m_start});
      chk("tx_data", {24'd0, tx_data}, {24'd0, m_data});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_bytes(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + 8'(i);
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("rx_byte_count", rx_q.size(), n);
  endtask

  initial begin
    // Reset then idle
    tick(2);
    reset = 1'b0;
    tick(100);
    chk("idle_empty", {31'd0, empty}, 32'd1);
    chk("idle_count", {27'd0, count}, 32'd0);
    chk("idle_tx_start", {31'd0, tx_start}, 32'd0);

    // Single byte: pulse appears in the cycle after the second edge
    wr_en = 1'b1; wr_data = 8'h54;
    tick(1);
    wr_en = 1'b0;
    chk("single_no_start_yet", {31'd0, tx_start}, 32'd0);
    tick(1);
    chk("single_tx_start", {31'd0, tx_start}, 32'd1);
    chk("single_tx_data", {24'd0, tx_data}, 32'h54);
    tick(1);
    chk("single_start_one_cycle", {31'd0, tx_start}, 32'd0);
    chk("single_empty_after", {31'd0, empty}, 32'd1);
    tb_ready = 1'b0;
    tick(2);

    // Burst through the serial transmitter
    sel = 1'b1;
    write_bytes(8'h41, 16);
    chk("burst_overflow", {31'd0, overflow}, 32'd0);
    wait_rx(16, 16 * 60);
    for (int i = 0; i < 16; i++)
      if (i < rx_q.size()) chk("burst_rx_byte", {24'd0, rx_q[i]}, 32'h41 + i);
    tick(5);
    rx_q.delete();

    // Overflow with ready held low, then drain exactly 16
    sel = 1'b0; tb_ready = 1'b0;
    tick(1);
    write_bytes(8'h60, 17);
    chk("ovf_count", {27'd0, count}, 32'd16);
    chk("ovf_full", {31'd0, full}, 32'd1);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    sel = 1'b1;
    wait_rx(16, 16 * 60);
    for (int i = 0; i < 16; i++)
      if (i < rx_q.size()) chk("ovf_rx_byte", {24'd0, rx_q[i]}, 32'h60 + i);
    tick(60);
    chk("ovf_drained_exactly_16", rx_q.size(), 16);
    chk("ovf_empty_after", {31'd0, empty}, 32'd1);
    rx_q.delete();

    // Pop and write together while full: write dropped
    sel = 1'b0; tb_ready = 1'b0;
    do_reset();
    write_bytes(8'h70, 16);
    chk("simul_full_count", {27'd0, count}, 32'd16);
    chk("simul_full_ovf_before", {31'd0, overflow}, 32'd0);
    tb_ready = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
    tick(1);
    wr_en = 1'b0; tb_ready = 1'b0;
    chk("simul_full_count_after", {27'd0, count}, 32'd15);
    chk("simul_full_ovf_after", {31'd0, overflow}, 32'd1);
    chk("simul_full_tx_data", {24'd0, tx_data}, 32'h70);
    tick(1);

    // Pop and write together at count 5: count holds
    do_reset();
    write_bytes(8'h80, 5);
    tb_ready = 1'b1; wr_en = 1'b1; wr_data = 8'hAB;
    tick(1);
    wr_en = 1'b0; tb_ready = 1'b0;
    chk("simul5_count", {27'd0, count}, 32'd5);
    chk("simul5_ovf", {31'd0, overflow}, 32'd0);
    chk("simul5_tx_data", {24'd0, tx_data}, 32'h80);
    tick(1);

    // Reset while waiting for busy
    do_reset();
    write_bytes(8'h90, 8);
    tb_ready = 1'b1;
    tick(3);
    chk("middrain_count", {27'd0, count}, 32'd7);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("middrain_count_reset", {27'd0, count}, 32'd0);
    chk("middrain_empty_reset", {31'd0, empty}, 32'd1);
    chk("middrain_tx_start_reset", {31'd0, tx_start}, 32'd0);
    wr_en = 1'b1; wr_data = 8'h99;
    tick(1);
    wr_en = 1'b0;
    tick(1);
    chk("resume_tx_start", {31'd0, tx_start}, 32'd1);
    chk("resume_tx_data", {24'd0, tx_data}, 32'h99);
    tb_ready = 1'b0;
    tick(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
